// File: rtl/regfile.sv
// regfile: architectural register file for the five-stage OpenMIPS pipeline.
// 32 x 32-bit general-purpose registers, r0 hardwired to zero.
// Two combinational read ports for decode, one write port from write-back,
// and a handshaked dump port that streams r0..r31 in order.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read port that
// addresses the register being written this cycle returns wdata immediately.

module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        dump_req,
  input  logic        dump_ready,
  output logic        dump_valid,
  output logic [4:0]  dump_addr,
  output logic [31:0] dump_data,
  output logic        dump_busy,
  output logic        dump_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } dump_state_e;

  logic [31:0] regs_r [32];

  dump_state_e state_r;
  dump_state_e state_nxt_s;
  logic        dump_valid_r;
  logic        valid_nxt_s;
  logic [4:0]  dump_addr_r;
  logic [4:0]  addr_nxt_s;
  logic [31:0] dump_data_r;
  logic [31:0] data_nxt_s;
  logic        dump_done_r;
  logic        done_nxt_s;

  logic        wr_en_s;
  logic [4:0]  next_idx_s;
  logic [31:0] next_load_s;

  // A write only has effect when enabled and not aimed at r0.
  assign wr_en_s    = we && (waddr != 5'd0);
  assign next_idx_s = dump_addr_r + 5'd1;

  // Register array: cleared on reset, r0 never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
    end else if (wr_en_s) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Read port 1: zero under reset, disable or r0; otherwise stored (or bypassed) value.
  always_comb begin
    rdata1 = 32'h0000_0000;
    if (rst || !re1 || (raddr1 == 5'd0)) begin
      rdata1 = 32'h0000_0000;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_en_s && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end
`endif
    else begin
      rdata1 = regs_r[raddr1];
    end
  end

  // Read port 2: identical rules to port 1.
  always_comb begin
    rdata2 = 32'h0000_0000;
    if (rst || !re2 || (raddr2 == 5'd0)) begin
      rdata2 = 32'h0000_0000;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_en_s && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end
`endif
    else begin
      rdata2 = regs_r[raddr2];
    end
  end

  // Value for the next dump beat; a same-edge write to that index is written through.
  always_comb begin
    next_load_s = 32'h0000_0000;
    if (wr_en_s && (waddr == next_idx_s)) begin
      next_load_s = wdata;
    end else begin
      next_load_s = regs_r[next_idx_s];
    end
  end

  // Dump FSM next-state and next-beat logic; beat is held while not accepted.
  always_comb begin
    state_nxt_s = state_r;
    valid_nxt_s = dump_valid_r;
    addr_nxt_s  = dump_addr_r;
    data_nxt_s  = dump_data_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (dump_req) begin
          state_nxt_s = ST_DUMP;
          valid_nxt_s = 1'b1;
          addr_nxt_s  = 5'd0;
          data_nxt_s  = 32'h0000_0000;  // r0 is always zero
        end else begin
          valid_nxt_s = 1'b0;
        end
      end
      ST_DUMP: begin
        if (dump_valid_r && dump_ready) begin
          if (dump_addr_r == 5'd31) begin
            state_nxt_s = ST_DONE;
            valid_nxt_s = 1'b0;
            done_nxt_s  = 1'b1;
          end else begin
            addr_nxt_s = next_idx_s;
            data_nxt_s = next_load_s;
          end
        end else begin
          addr_nxt_s = dump_addr_r;
          data_nxt_s = dump_data_r;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        valid_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        valid_nxt_s = 1'b0;
        addr_nxt_s  = 5'd0;
        data_nxt_s  = 32'h0000_0000;
      end
    endcase
  end

  // Dump FSM state and registered dump outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      dump_valid_r <= 1'b0;
      dump_addr_r  <= 5'd0;
      dump_data_r  <= 32'h0000_0000;
      dump_done_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      dump_valid_r <= valid_nxt_s;
      dump_addr_r  <= addr_nxt_s;
      dump_data_r  <= data_nxt_s;
      dump_done_r  <= done_nxt_s;
    end
  end

  assign dump_valid = dump_valid_r;
  assign dump_addr  = dump_addr_r;
  assign dump_data  = dump_data_r;
  assign dump_done  = dump_done_r;
  assign dump_busy  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: self-checking bench for regfile using a plain array model.

module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        dump_req;
  logic        dump_ready;
  logic        dump_valid;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_busy;
  logic        dump_done;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [31:0] model [32];
  int n_checks = 0;
  int n_fail   = 0;

  regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .dump_req(dump_req), .dump_ready(dump_ready), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_busy(dump_busy),
    .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference read: what a read port must show given the current inputs.
  function automatic logic [31:0] exp_read(input logic en, input logic [4:0] a);
    if (rst || !en || a == 5'd0) return 32'h0;
    if (BYPASS && we && waddr != 5'd0 && a == waddr) return wdata;
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Advance one clock edge, committing any driven write to the model.
  task automatic tick();
    if (we && waddr != 5'd0 && !rst) model[waddr] = wdata;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic start_dump();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    we = 1'b1; waddr = 5'd3; wdata = 32'h3333_0003; tick();
    we = 1'b1; waddr = 5'd9; wdata = 32'h9999_0009; tick();
    dump_ready = 1'b1;
    start_dump();
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (dump_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dump_valid); end
    n_checks++; if (dump_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", dump_busy); end
    n_checks++; if (dump_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", dump_done); end
    n_checks++; if (dump_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", dump_addr); end
    n_checks++; if (dump_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", dump_data); end
    for (int a = 0; a < 32; a++) begin
      re1 = 1'b1; raddr1 = 5'(a); re2 = 1'b1; raddr2 = 5'(31 - a);
      #1;
      n_checks++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 r%0d: got %h want 0", a, rdata1); end
      n_checks++; if (rdata2 !== 32'h0) begin n_fail++; $display("FAIL reset_rd2 r%0d: got %h want 0", 31 - a, rdata2); end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    for (int a = 0; a < 32; a++) begin
      re1 = 1'b1; raddr1 = 5'(a);
      #1;
      n_checks++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL cleared r%0d: got %h want 0", a, rdata1); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; tick();
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
    #1;
    n_checks++; if (rdata1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rd1: got %h want deadbeef", rdata1); end
    n_checks++; if (rdata2 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rd2: got %h want deadbeef", rdata2); end
    re2 = 1'b0;
    #1;
    n_checks++; if (rdata2 !== 32'h0) begin n_fail++; $display("FAIL re_off: got %h want 0", rdata2); end
    we = 1'b1; waddr = 5'd0; wdata = 32'h0000_1234; tick();
    re1 = 1'b1; raddr1 = 5'd0;
    #1;
    n_checks++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL r0_write: got %h want 0", rdata1); end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd7; wdata = 32'h0101_0101; tick();
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5;
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b0; raddr2 = 5'd7;
    #1;
    n_checks++;
    if (rdata1 !== (BYPASS ? 32'hA5A5_A5A5 : 32'h0101_0101)) begin
      n_fail++; $display("FAIL bypass_same: got %h want %h", rdata1, BYPASS ? 32'hA5A5_A5A5 : 32'h0101_0101);
    end
    n_checks++; if (rdata2 !== 32'h0) begin n_fail++; $display("FAIL bypass_re_off: got %h want 0", rdata2); end
    tick();
    #1;
    n_checks++; if (rdata1 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL bypass_next: got %h want a5a5a5a5", rdata1); end
  endtask

  task automatic test_random_rw();
    logic [31:0] e1;
    logic [31:0] e2;
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1)); waddr = 5'($urandom); wdata = $urandom;
      re1 = ($urandom_range(0, 7) != 0); re2 = ($urandom_range(0, 7) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      #1;
      e1 = exp_read(re1, raddr1);
      e2 = exp_read(re2, raddr2);
      n_checks++; if (rdata1 !== e1) begin n_fail++; $display("FAIL rand_rd1 it%0d r%0d: got %h want %h", i, raddr1, rdata1, e1); end
      n_checks++; if (rdata2 !== e2) begin n_fail++; $display("FAIL rand_rd2 it%0d r%0d: got %h want %h", i, raddr2, rdata2, e2); end
      tick();
    end
  endtask

  task automatic test_full_dump();
    logic [31:0] kv;
    re1 = 1'b0; re2 = 1'b0;
    for (int k = 1; k < 32; k++) begin
      kv = 32'(k) * 32'h1111_1111;
      we = 1'b1; waddr = 5'(k); wdata = kv; tick();
    end
    dump_ready = 1'b1;
    start_dump();
    for (int c = 1; c <= 36; c++) begin
      dump_req = (c >= 5 && c <= 20);
      #1;
      n_checks++; if (dump_valid !== (c <= 32)) begin n_fail++; $display("FAIL full_valid c%0d: got %b want %b", c, dump_valid, c <= 32); end
      n_checks++; if (dump_busy !== (c <= 33)) begin n_fail++; $display("FAIL full_busy c%0d: got %b want %b", c, dump_busy, c <= 33); end
      n_checks++; if (dump_done !== (c == 33)) begin n_fail++; $display("FAIL full_done c%0d: got %b want %b", c, dump_done, c == 33); end
      if (c <= 32) begin
        kv = 32'(c - 1) * 32'h1111_1111;
        n_checks++; if (dump_addr !== 5'(c - 1)) begin n_fail++; $display("FAIL full_addr c%0d: got %0d want %0d", c, dump_addr, c - 1); end
        n_checks++; if (dump_data !== kv) begin n_fail++; $display("FAIL full_data c%0d: got %h want %h", c, dump_data, kv); end
      end
      tick();
    end
    dump_req = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] old10;
    dump_ready = 1'b1;
    start_dump();
    for (int b = 0; b < 10; b++) begin
      #1;
      n_checks++; if (dump_addr !== 5'(b) || dump_data !== model[b]) begin n_fail++; $display("FAIL bp_beat%0d: got %0d/%h want %0d/%h", b, dump_addr, dump_data, b, model[b]); end
      tick();
    end
    old10 = model[10];
    dump_ready = 1'b0;
    for (int h = 0; h < 3; h++) begin
      if (h == 1) begin we = 1'b1; waddr = 5'd10; wdata = ~old10; end
      #1;
      n_checks++; if (dump_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid h%0d: got %b want 1", h, dump_valid); end
      n_checks++; if (dump_addr !== 5'd10 || dump_data !== old10) begin n_fail++; $display("FAIL bp_hold h%0d: got %0d/%h want 10/%h", h, dump_addr, dump_data, old10); end
      tick();
    end
    dump_ready = 1'b1;
    we = 1'b1; waddr = 5'd11; wdata = 32'h5555_AAAA;
    #1;
    n_checks++; if (dump_addr !== 5'd10 || dump_data !== old10) begin n_fail++; $display("FAIL bp_release: got %0d/%h want 10/%h", dump_addr, dump_data, old10); end
    tick();
    #1;
    n_checks++; if (dump_addr !== 5'd11 || dump_data !== 32'h5555_AAAA) begin n_fail++; $display("FAIL bp_collide: got %0d/%h want 11/5555aaaa", dump_addr, dump_data); end
    for (int b = 11; b < 32; b++) begin
      n_checks++; if (dump_valid !== 1'b1 || dump_addr !== 5'(b) || dump_data !== model[b]) begin n_fail++; $display("FAIL bp_beat%0d: got %b/%0d/%h want 1/%0d/%h", b, dump_valid, dump_addr, dump_data, b, model[b]); end
      tick();
      #1;
    end
    n_checks++; if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done: got done %b valid %b want 1/0", dump_done, dump_valid); end
    tick();
    #1;
    n_checks++; if (dump_busy !== 1'b0 || dump_done !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got busy %b done %b want 0/0", dump_busy, dump_done); end
  endtask

  task automatic test_reset_mid_dump();
    int budget;
    dump_ready = 1'b1;
    start_dump();
    for (int b = 0; b < 15; b++) tick();
    #1;
    n_checks++; if (dump_addr !== 5'd15 || dump_data !== model[15]) begin n_fail++; $display("FAIL rmd_beat15: got %0d/%h want 15/%h", dump_addr, dump_data, model[15]); end
    #2;
    rst = 1'b1;
    re1 = 1'b1; raddr1 = 5'd15;
    #1;
    n_checks++; if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0) begin n_fail++; $display("FAIL rmd_flags: got v%b b%b d%b want 000", dump_valid, dump_busy, dump_done); end
    n_checks++; if (dump_addr !== 5'd0 || dump_data !== 32'h0) begin n_fail++; $display("FAIL rmd_beat: got %0d/%h want 0/0", dump_addr, dump_data); end
    n_checks++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL rmd_rd: got %h want 0", rdata1); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    start_dump();
    #1;
    n_checks++; if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_addr !== 5'd0 || dump_data !== 32'h0) begin n_fail++; $display("FAIL rmd_restart: got v%b b%b %0d/%h want 1 1 0/0", dump_valid, dump_busy, dump_addr, dump_data); end
    tick();
    #1;
    n_checks++; if (dump_addr !== 5'd1 || dump_data !== 32'h0) begin n_fail++; $display("FAIL rmd_beat1: got %0d/%h want 1/0", dump_addr, dump_data); end
    budget = 0;
    while (dump_busy && budget < 40) begin
      tick();
      budget++;
    end
    n_checks++; if (dump_busy !== 1'b0) begin n_fail++; $display("FAIL rmd_finish: busy %b after %0d cycles want 0", dump_busy, budget); end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
    dump_req = 1'b0; dump_ready = 1'b0;
    clear_model();
    test_reset();
    test_write_read();
    test_bypass();
    test_random_rw();
    test_full_dump();
    test_backpressure();
    test_reset_mid_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

Architectural register file for the five-stage OpenMIPS pipeline. It holds 32 general-purpose 32-bit registers and is written from the write-back stage outputs (`wb_wreg`, `wb_wd`, `wb_wdata`). The decode stage reads it through two combinational read ports. A handshaked dump port streams all 32 registers out in order for bench and debug inspection.

## Interface
Parameters: none. Widths come from `RegisterBus` (32) and `RegisterAddressBus` (5).

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset (`ResetEnable` = 1). Clears all registers and the dump FSM.
- `we`  in  1  write enable; driven by `wb_wreg`.
- `waddr`  in  5  write address; driven by `wb_wd`.
- `wdata`  in  32  write data; driven by `wb_wdata`.
- `re1`  in  1  read enable, port 1.
- `raddr1`  in  5  read address, port 1.
- `rdata1`  out  32  read data, port 1 (combinational).
- `re2`  in  1  read enable, port 2.
- `raddr2`  in  5  read address, port 2.
- `rdata2`  out  32  read data, port 2 (combinational).
- `dump_req`  in  1  start a dump; sampled only in IDLE.
- `dump_ready`  in  1  consumer accepts the current beat.
- `dump_valid`  out  1  beat present on `dump_addr`/`dump_data`.
- `dump_addr`  out  5  register index of the current beat.
- `dump_data`  out  32  register value of the current beat.
- `dump_busy`  out  1  FSM is in DUMP or DONE.
- `dump_done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
**Write**
- On a clock edge with `we`=1 and `waddr`≠0, `wdata` is stored in `regs[waddr]`.
- Writes to r0 are discarded.

**Read** (each port independently)
- `rdata` = 0 if `rst`=1, `re`=0, or `raddr`=0.
- Otherwise `rdata` = `regs[raddr]`, subject to the bypass rule under Configuration.

**Dump FSM**, states IDLE, DUMP, DONE:
- **IDLE**
  - `dump_req`=1 → DUMP; load `dump_addr`=0, `dump_data`=`regs[0]`=0, `dump_valid`=1.
- **DUMP**
  - `dump_valid`=1 and `dump_ready`=1 with `dump_addr`<31: increment `dump_addr`; load `dump_data` ← `regs[dump_addr+1]`.
  - Accept with `dump_addr`=31 → DONE; `dump_valid` ← 0.
  - While `dump_ready`=0, `dump_addr` and `dump_data` are held stable (snapshot). A write to the displayed register does not alter the held beat.
- **DONE**
  - `dump_done`=1 for exactly one cycle, then → IDLE.
- `dump_req` is ignored in DUMP and DONE.

**Dump data load**
- When `dump_data` is loaded at the same edge as a write to the same address, the loaded value is `wdata`.
- This write-through applies regardless of the macro.

**Reset**
- Asynchronous; may assert at any time, including mid-dump.
- All 32 registers ← 0; FSM → IDLE.
- `dump_valid`, `dump_busy`, `dump_done` ← 0; `dump_addr` ← 0; `dump_data` ← 0.
- `rdata1`/`rdata2` read 0 while `rst`=1.

## Timing
- Read latency: 0 cycles (combinational from address, enable and stored state).
- Write visibility:
  - with bypass: same cycle;
  - without bypass: the cycle after the write edge.
- Dump:
  - `dump_req` high in IDLE at edge n → `dump_valid`=1 from cycle n+1.
  - With `dump_ready` held at 1: beats at cycles n+1 … n+32, `dump_done` at n+33, back in IDLE at n+34.
  - Each cycle with `dump_ready`=0 stretches the sequence by one cycle.
- `dump_busy` = (state ≠ IDLE), decoded from state registers.

## Configuration
Macro `REGFILE_BYPASS_EN` controls read-port bypass.
- **Defined:** when `we`=1, `waddr`≠0, `re`=1 and `raddr`==`waddr`, the read port returns `wdata` in the same cycle. This resolves the WB→ID hazard without a stall.
- **Undefined:** read ports return only stored contents. The WB→ID hazard must be handled upstream by stall or forwarding.
- The dump path is unaffected by the macro.

## Test plan
1. Reset state: assert `rst` mid-cycle → every register reads 0 on both ports; all dump outputs read 0.
2. Write/read: write r5 = 0xDEADBEEF, then read r5 on both ports next cycle → 0xDEADBEEF. Write r0 = 0x1234 → r0 reads 0.
3. Bypass:
   - In the same cycle, `we`=1, `waddr`=7, `wdata`=0xA5A5A5A5, `raddr1`=7, `re1`=1.
   - Defined → `rdata1`=0xA5A5A5A5.
   - Undefined → old value that cycle, 0xA5A5A5A5 the next cycle.
4. Full dump with `dump_ready`=1, after writing r_k = k·0x11111111 for k=1..31 → 32 beats with `dump_addr` 0..31, matching data, one-cycle `dump_done`, `dump_busy` high for 33 cycles.
5. Backpressure and collision:
   - Drop `dump_ready` for 3 cycles at beat 10 → beat 10 is held unchanged, even if r10 is written meanwhile.
   - Writing r11 = 0x5555AAAA at the edge that accepts beat 10 → beat 11 shows 0x5555AAAA.
6. Reset mid-dump: assert `rst` at beat 15 → outputs clear immediately and the FSM is in IDLE. A new `dump_req` after release restarts at `dump_addr`=0.
